bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It sits directly upstream of the four-digit seven-segment display driver. It converts a binary count, such as a counter or ADC value, into four BCD digits d3..d0 that connect straight to the driver's digit inputs. Conversion uses a start/done handshake. The digit outputs hold their value between conversions, so the display stays stable.

Parameters:
W, 14, binary input width; legal range 4..16
MAX_VAL, 9999, largest value representable on four digits; larger inputs flag overflow

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  conversion request, sampled only in IDLE
bin  input  W  binary value, captured on the edge that accepts start
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when new digits are valid
ovf  output  1  high when the last accepted bin exceeded MAX_VAL; held until next accept
d3  output  4  thousands digit (BCD, or 4'hE on overflow)
d2  output  4  hundreds digit
d1  output  4  tens digit
d0  output  4  units digit

Behaviour:
- Reset (async, rst=1): state=IDLE; d3..d0=0; busy=0; done=0; ovf=0; internal shift/BCD regs and count cleared. Reset mid-conversion aborts it; no done pulse is produced.
- States: IDLE, SHIFT, DONE; registered.
- IDLE, start=1 at edge k:
  - bin_reg<=bin; bcd_reg(16b)<=0; count<=0; busy<=1.
  - ovf_pend<=(bin>MAX_VAL).
  - next state SHIFT.
- IDLE, start=0: hold everything. done<=0 on every edge except the DONE->IDLE edge.
- SHIFT, edges k+1..k+W, one per edge:
  - Each BCD nibble >=5 gets +3 (combinational, 4-bit result, no carry out).
  - {bcd_reg,bin_reg} shifted left by 1; the MSB of bin_reg enters bcd_reg[0].
  - count++; when count==W-1 on that edge, next state is DONE.
- DONE, edge k+W+1:
  - d3..d0<=bcd_reg nibbles, or all 4'hE if ovf_pend.
  - ovf<=ovf_pend; done<=1; busy<=0; next state IDLE.
- Latency: done is high in the cycle after edge k+W+1. For W=14 that is 16 cycles from start acceptance. Throughput is one conversion per W+2 cycles.
- start while busy=1 is ignored and not queued. bin changes during a conversion have no effect.
- start=1 in the same cycle done=1 is accepted, because the state is already IDLE. That gives back-to-back conversions.
- start held high continuously produces a new conversion every W+2 cycles.
- Outputs change only on the DONE edge or on reset. The display therefore never shows partial results.
- Overflow: values above 9999 cannot be shown. Output is "EEEE" with ovf=1. For W<14, ovf is constant 0 (MAX_VAL compare is always false).
- The 16-bit BCD register is sized for 4 digits. Any thousands-digit overflow during shifting for inputs >9999 is discarded, and the result is replaced by 4'hE.

Decomposition:
- Shared package:
  - State encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - ERR_DIGIT=4'hE.
  - NUM_DIGITS=4.
  - Default MAX_VAL=9999.
- Sub-module bcd_add3: combinational 4-bit in/out, returns in+3 when in>=5, else in. Instantiated 4 times on the nibbles of bcd_reg.
- Top-level holds the FSM, the counter (ceil(log2(W))+1 bits) and the output registers.

Test Plan:
1. Reset, then observe with no start -> d3..d0=0,0,0,0; busy=0; done=0; ovf=0. Assert rst mid-SHIFT -> all outputs 0 next cycle, no done pulse.
2. start with bin=1234 (W=14) -> busy=1 for 15 cycles; done=1 exactly 16 cycles after acceptance; d3..d0=1,2,3,4; ovf=0.
3. Boundary values:
   - bin=0 -> 0,0,0,0.
   - bin=9999 -> 9,9,9,9 with ovf=0.
   - bin=10000 -> E,E,E,E with ovf=1.
   - bin=16383 -> E,E,E,E with ovf=1.
4. start bin=42, then pulse start with bin=777 while busy -> second request ignored; result 0,0,4,2. Digits hold 0,0,4,2 until a new conversion.
5. Back-to-back: start bin=5, then start bin=9876 in the done cycle -> done pulses at cycles 16 and 32; digits 0,0,0,5 then 9,8,7,6.
6. ovf clearing: convert 12000 (ovf=1, EEEE), then 300 -> ovf=0, digits 0,3,0,0. Randomized bin in 0..9999 checked against a div/mod reference model.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// bin2bcd_seq_pkg: shared state encoding and digit constants for the BCD converter
package bin2bcd_seq_pkg;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_t;
    localparam logic [3:0] ERR_DIGIT = 4'hE;
    localparam int NUM_DIGITS = 4;
    localparam int DEF_MAX_VAL = 9999;
endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// bcd_add3: double-dabble nibble correction, adds 3 when the digit is 5 or more
module bcd_add3
    import bin2bcd_seq_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);
    always_comb dout = din >= 4'd5 ? din + 4'd3 : din;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary to four-digit BCD converter
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int W = 14,
    parameter int MAX_VAL = DEF_MAX_VAL
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic [3:0]   d3,
    output logic [3:0]   d2,
    output logic [3:0]   d1,
    output logic [3:0]   d0
);
    localparam int CW = $clog2(W) + 1;
    localparam int BW = 4 * NUM_DIGITS;
    state_t state, state_nx;
    logic [W-1:0] bin_reg;
    logic [BW-1:0] bcd_reg, bcd_adj;
    logic [CW-1:0] count;
    logic ovf_pend;
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (.din(bcd_reg[4*i +: 4]), .dout(bcd_adj[4*i +: 4]));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state == ST_IDLE  ? (start ? ST_SHIFT : ST_IDLE) :
                   state == ST_SHIFT ? (count == CW'(W - 1) ? ST_DONE : ST_SHIFT) :
                   ST_IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_reg <= '0;
            bcd_reg <= '0;
            count <= '0;
            ovf_pend <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            ovf <= 1'b0;
            {d3, d2, d1, d0} <= '0;
        end else begin
            done <= state == ST_DONE;
            busy <= state_nx != ST_IDLE;
            case (state)
                ST_IDLE: if (start) begin
                    bin_reg <= bin;
                    bcd_reg <= '0;
                    count <= '0;
                    ovf_pend <= 32'(bin) > 32'(MAX_VAL);
                end
                ST_SHIFT: begin
                    // thousands-digit carry is dropped; such inputs are flagged as overflow anyway
                    bcd_reg <= {bcd_adj[BW-2:0], bin_reg[W-1]};
                    bin_reg <= bin_reg << 1;
                    count <= count + 1'b1;
                end
                ST_DONE: begin
                    {d3, d2, d1, d0} <= ovf_pend ? {NUM_DIGITS{ERR_DIGIT}} : bcd_reg;
                    ovf <= ovf_pend;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: scoreboard bench for bin2bcd_seq with directed and random conversions
module tb_bin2bcd_seq;
    localparam int W = 14;
    typedef struct {logic [15:0] dig; logic ovf;} exp_t;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [W-1:0] bin = '0;
    logic busy, done, ovf;
    logic [3:0] d3, d2, d1, d0;
    int checks = 0, errors = 0;
    exp_t q[$];
    exp_t e_mon;

    bin2bcd_seq #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin), .busy(busy), .done(done),
        .ovf(ovf), .d3(d3), .d2(d2), .d1(d1), .d0(d0)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(int v);
        if (v > 9999) return 16'hEEEE;
        return {4'(v / 1000), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(int v);
        q.push_back('{dig: model(v), ovf: v > 9999});
    endtask

    // accepts a request now and follows it to its done pulse, checking timing
    task automatic run(int v);
        int n = 0, bc = 0;
        bin = W'(v);
        start = 1'b1;
        push(v);
        while (n < 40) begin
            tick();
            start = 1'b0;
            n++;
            if (busy) bc++;
            if (done) break;
        end
        chk("latency", n, W + 2);
        chk("busy_cycles", bc, W + 1);
        chk("busy_at_done", busy, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) chk("unexpected_done", done, 0);
            else begin
                e_mon = q.pop_front();
                chk("digits", {d3, d2, d1, d0}, e_mon.dig);
                chk("ovf", ovf, e_mon.ovf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n, first, second;
        repeat (2) tick();
        chk("rst_digits", {d3, d2, d1, d0}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_digits", {d3, d2, d1, d0}, 0);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);

        run(1234);
        run(0);
        run(9999);
        run(10000);
        run(16383);

        // abort a conversion with reset; nothing must come out of it
        tick();
        bin = W'(555);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("abort_digits", {d3, d2, d1, d0}, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_ovf", ovf, 0);
        tick();
        rst = 1'b0;
        repeat (20) tick();

        // a request during busy is dropped
        bin = W'(42);
        start = 1'b1;
        push(42);
        tick();
        start = 1'b0;
        repeat (3) tick();
        bin = W'(777);
        start = 1'b1;
        tick();
        start = 1'b0;
        bin = W'(123);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk("ignored_done_seen", done, 1);
        repeat (10) tick();
        chk("hold_digits", {d3, d2, d1, d0}, 16'h0042);
        chk("hold_done", done, 0);
        chk("hold_busy", busy, 0);

        run(5);
        run(9876);
        run(12000);
        run(300);
        repeat (20) run(int'($urandom_range(0, 9999)));
        repeat (3) run(int'($urandom_range(10000, 16383)));

        // held start: conversions repeat every W+2 cycles
        tick();
        bin = W'(321);
        start = 1'b1;
        push(321);
        push(321);
        n = 0;
        first = 0;
        second = 0;
        while (n < 80 && second == 0) begin
            tick();
            n++;
            if (done && first == 0) first = n;
            else if (done) second = n;
        end
        start = 1'b0;
        chk("held_first", first, W + 2);
        chk("held_spacing", second - first, W + 2);
        repeat (W + 4) tick();
        chk("held_idle_busy", busy, 0);
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
